// File: rtl/logic_unit_arbiter.sv
// Four-requester round-robin arbiter in front of one shared bitwise logic unit (NOR/AND/OR/XOR).
// Define LOGIC_ARB_PRIO_EN to give requester 0 absolute priority over round-robin requesters 1-3.
module logic_unit_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [3:0]         req,
   input  logic [7:0]         op,
   input  logic [4*WIDTH-1:0] a_in,
   input  logic [4*WIDTH-1:0] b_in,
   output logic [3:0]         gnt,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [1:0]         res_id,
   output logic [WIDTH-1:0]   res,
   output logic               busy
);

   typedef enum logic [1:0] {IDLE, CAPT, RESP} state_t;

   state_t           state_reg, state_next;
   logic [1:0]       last_reg;
   logic [1:0]       winner;
   logic             found;
   logic [1:0]       op_arr [4];
   logic [WIDTH-1:0] a_arr  [4];
   logic [WIDTH-1:0] b_arr  [4];
   logic [1:0]       op_reg;
   logic [WIDTH-1:0] a_reg, b_reg;
   logic [1:0]       id_reg;
   logic [WIDTH-1:0] unit_out;
   logic [WIDTH-1:0] res_reg;
   logic [1:0]       res_id_reg;
   logic             res_valid_reg;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_slice
         assign op_arr[gi] = op[2*gi +: 2];
         assign a_arr[gi]  = a_in[gi*WIDTH +: WIDTH];
         assign b_arr[gi]  = b_in[gi*WIDTH +: WIDTH];
      end
   endgenerate

`ifdef LOGIC_ARB_PRIO_EN
   // last_reg only ever tracks requesters 1-3 here, so the rotation stays within that group.
   always_comb begin
      int cand;
      winner = 2'd0;
      found  = 1'b0;
      cand   = 0;
      if (req[0]) begin
         found = 1'b1;
      end else begin
         for (int k = 1; k <= 3; k++) begin
            cand = ((int'(last_reg) - 1 + k) % 3) + 1;
            if (!found && req[2'(cand)]) begin
               winner = 2'(cand);
               found  = 1'b1;
            end
         end
      end
   end
`else
   always_comb begin
      logic [1:0] idx;
      winner = 2'd0;
      found  = 1'b0;
      idx    = 2'd0;
      for (int k = 1; k <= 4; k++) begin
         idx = last_reg + 2'(k);
         if (!found && req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (found) state_next = CAPT;
         CAPT:    state_next = RESP;
         RESP:    if (res_valid_reg && res_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Grant is combinational in the arbitration cycle; masking with rst_n keeps it low during reset.
   always_comb begin
      gnt  = 4'b0000;
      busy = (state_reg != IDLE);
      if (state_reg == IDLE && found && rst_n) gnt[winner] = 1'b1;
   end

   always_comb begin
      case (op_reg)
         2'b00:   unit_out = ~(a_reg | b_reg);
         2'b01:   unit_out = a_reg & b_reg;
         2'b10:   unit_out = a_reg | b_reg;
         default: unit_out = a_reg ^ b_reg;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_reg      <= 2'd3;
         op_reg        <= 2'd0;
         a_reg         <= '0;
         b_reg         <= '0;
         id_reg        <= 2'd0;
         res_reg       <= '0;
         res_id_reg    <= 2'd0;
         res_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (found) begin
                  op_reg <= op_arr[winner];
                  a_reg  <= a_arr[winner];
                  b_reg  <= b_arr[winner];
                  id_reg <= winner;
`ifdef LOGIC_ARB_PRIO_EN
                  if (winner != 2'd0) last_reg <= winner;
`else
                  last_reg <= winner;
`endif
               end
            end
            CAPT: begin
               res_reg       <= unit_out;
               res_id_reg    <= id_reg;
               res_valid_reg <= 1'b1;
            end
            RESP: begin
               if (res_valid_reg && res_ready) res_valid_reg <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign res       = res_reg;
   assign res_id    = res_id_reg;
   assign res_valid = res_valid_reg;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: vector table plus hold, reset and rotation sequences.
module tb_logic_unit_arbiter;

   localparam int W = 32;
   localparam logic [127:0] AF = {4{32'hFFFFFFFF}};
   localparam logic [127:0] BV = {4{32'h007FA509}};
   localparam logic [127:0] AX = {32'hDEADBEEF, 32'h12345678, 32'h0F0F0F0F, 32'hAAAAAAAA};
   localparam logic [127:0] BX = {32'h11111111, 32'h9ABCDEF0, 32'h00FF00FF, 32'h55555555};

   logic           clk;
   logic           rst_n;
   logic [3:0]     req;
   logic [7:0]     op;
   logic [4*W-1:0] a_in, b_in;
   logic [3:0]     gnt;
   logic           res_valid;
   logic           res_ready;
   logic [1:0]     res_id;
   logic [W-1:0]   res;
   logic           busy;

   int ntests = 0;
   int nfail  = 0;

   typedef struct {
      logic [3:0]   req;
      logic [7:0]   op;
      logic [127:0] a;
      logic [127:0] b;
      logic [3:0]   gnt;
      logic [31:0]  res;
      logic [1:0]   id;
   } vec_t;

   vec_t vecs [9];

   logic [3:0]  rot_gnt [4];
   logic [31:0] rot_res [4];
   logic [1:0]  rot_id  [4];

   logic_unit_arbiter #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .op(op), .a_in(a_in), .b_in(b_in),
      .gnt(gnt), .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
      .res(res), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end else begin
         $display("ok   %s = %0h", nm, act);
      end
   endtask

   // Called on a falling edge with the DUT in IDLE; returns on a falling edge back in IDLE.
   task automatic run_txn(input string nm, input logic [3:0] rq, input logic [7:0] o,
                          input logic [127:0] av, input logic [127:0] bv,
                          input logic [3:0] eg, input logic [31:0] er, input logic [1:0] ei);
      req = rq; op = o; a_in = av; b_in = bv; res_ready = 1'b1;
      #1 chk({nm, "_gnt"}, gnt, eg);
      @(posedge clk); #1;
      op = ~o; a_in = ~av; b_in = ~bv;
      chk({nm, "_capt_busy"}, busy, 1'b1);
      chk({nm, "_capt_valid"}, res_valid, 1'b0);
      chk({nm, "_capt_gnt"}, gnt, 4'b0000);
      @(posedge clk); #1;
      chk({nm, "_valid"}, res_valid, 1'b1);
      chk({nm, "_res"}, res, er);
      chk({nm, "_id"}, res_id, ei);
      @(posedge clk); #1;
      chk({nm, "_idle_busy"}, busy, 1'b0);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req = 4'b0000;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      vecs[0] = '{4'b0001, 8'h00, 128'h0, 128'h0, 4'b0001, 32'hFFFFFFFF, 2'd0};
      vecs[1] = '{4'b1110, 8'hE4, AF, BV, 4'b0010, 32'h007FA509, 2'd1};
      vecs[2] = '{4'b1100, 8'hE4, AF, BV, 4'b0100, 32'hFFFFFFFF, 2'd2};
      vecs[3] = '{4'b1000, 8'hE4, AF, BV, 4'b1000, 32'hFF805AF6, 2'd3};
      vecs[4] = '{4'b0011, 8'hE4, AF, BV, 4'b0001, 32'h00000000, 2'd0};
      vecs[5] = '{4'b0110, 8'h04, AX, BX, 4'b0010, 32'h000F000F, 2'd1};
      vecs[6] = '{4'b1100, 8'h80, AX, BX, 4'b0100, 32'h65432107, 2'd2};
      vecs[7] = '{4'b0010, 8'h0C, AX, BX, 4'b0010, 32'h0FF00FF0, 2'd1};
      vecs[8] = '{4'b1000, 8'hC0, AX, BX, 4'b1000, 32'hCFBCAFFE, 2'd3};
`ifdef LOGIC_ARB_PRIO_EN
      rot_gnt = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
      rot_res = '{32'h0, 32'h0, 32'h0, 32'h0};
      rot_id  = '{2'd0, 2'd0, 2'd0, 2'd0};
`else
      rot_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      rot_res = '{32'h0, 32'h007FA509, 32'hFFFFFFFF, 32'hFF805AF6};
      rot_id  = '{2'd0, 2'd1, 2'd2, 2'd3};
`endif

      // Reset state, with all requests high to prove the grant stays masked.
      rst_n = 1'b0; req = 4'b1111; op = 8'h00; a_in = '0; b_in = '0; res_ready = 1'b0;
      #3;
      chk("rst_gnt", gnt, 4'b0000);
      chk("rst_valid", res_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_res", res, 32'h0);
      chk("rst_id", res_id, 2'd0);
      @(negedge clk); @(negedge clk);
      req = 4'b0000;
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++)
         run_txn($sformatf("vec%0d", i), vecs[i].req, vecs[i].op, vecs[i].a, vecs[i].b,
                 vecs[i].gnt, vecs[i].res, vecs[i].id);

      // All four requesting continuously from reset.
      do_reset();
      for (int i = 0; i < 4; i++)
         run_txn($sformatf("rot%0d", i), 4'b1111, 8'hE4, AF, BV, rot_gnt[i], rot_res[i], rot_id[i]);

      // Consumer stalls for five cycles while other requests pile up.
      req = 4'b0010; op = 8'h0C; a_in = AF; b_in = AF; res_ready = 1'b0;
      #1 chk("hold_gnt", gnt, 4'b0010);
      @(posedge clk); #1;
      req = 4'b1111;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("hold%0d_valid", i), res_valid, 1'b1);
         chk($sformatf("hold%0d_res", i), res, 32'h0);
         chk($sformatf("hold%0d_id", i), res_id, 2'd1);
         chk($sformatf("hold%0d_gnt", i), gnt, 4'b0000);
         chk($sformatf("hold%0d_busy", i), busy, 1'b1);
         @(posedge clk); #1;
      end
      req = 4'b0000; res_ready = 1'b1;
      @(posedge clk); #1;
      chk("hold_acc_valid", res_valid, 1'b0);
      chk("hold_acc_busy", busy, 1'b0);
      @(negedge clk);

      // Reset pulse while a result is waiting.
      req = 4'b0100; op = 8'h00; a_in = AF; b_in = BV; res_ready = 1'b0;
      #1 chk("mid_gnt", gnt, 4'b0100);
      @(posedge clk); #1;
      req = 4'b0000;
      @(posedge clk); #1;
      chk("mid_valid_pre", res_valid, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_valid_rst", res_valid, 1'b0);
      chk("mid_busy_rst", busy, 1'b0);
      chk("mid_res_rst", res, 32'h0);
      @(negedge clk);
      rst_n = 1'b1; res_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk($sformatf("mid_idle%0d_valid", i), res_valid, 1'b0);
      end
      run_txn("mid_next", 4'b1111, 8'hE4, AF, BV, 4'b0001, 32'h0, 2'd0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
